// File: rtl/axis_dispatch_pkg.sv
// rtl/axis_dispatch_pkg.sv - shared constants and FSM encoding for the 4-way stream dispatcher
package axis_dispatch_pkg;
    localparam int DEST_W = 2;
    localparam int N_OUT  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;
endpackage

// File: rtl/axis_dispatch_out_reg.sv
// rtl/axis_dispatch_out_reg.sv - one-deep output register slice (valid/data/last) with ready pass-through
module axis_dispatch_out_reg #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  free,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready
);
    // Slot can take a new beat when empty or when its current beat leaves this cycle.
    assign free = !m_axis_tvalid || m_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= load_data;
            m_axis_tlast  <= load_last;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end
endmodule

// File: rtl/axis_dispatch_4.sv
// rtl/axis_dispatch_4.sv - routes whole packets to one of four outputs by head-beat dest field
// Optional drop counter: AXIS_DISPATCH_DROP_CNT_EN
module axis_dispatch_4
    import axis_dispatch_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEST_LSB   = 62
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            oen,
    input  logic                  s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  m00_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m00_axis_tdata,
    output logic                  m00_axis_tlast,
    input  logic                  m00_axis_tready,
    output logic                  m01_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m01_axis_tdata,
    output logic                  m01_axis_tlast,
    input  logic                  m01_axis_tready,
    output logic                  m02_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m02_axis_tdata,
    output logic                  m02_axis_tlast,
    input  logic                  m02_axis_tready,
    output logic                  m03_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m03_axis_tdata,
    output logic                  m03_axis_tlast,
    input  logic                  m03_axis_tready,
    output logic [15:0]           drop_cnt
);
    state_t              state_q, state_d;
    logic [DEST_W-1:0]   dest_q, dest_d, head_dest, target;
    logic                ready, fwd, drop_inc, accept;
    logic [N_OUT-1:0]    free, load, o_valid, o_last, o_ready;
    logic [DATA_WIDTH-1:0] o_data [N_OUT];

    assign head_dest     = s_axis_tdata[DEST_LSB +: DEST_W];
    assign accept        = s_axis_tvalid && ready;
    assign s_axis_tready = rst_n && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dest_q  <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dest_d   = dest_q;
        target   = dest_q;
        ready    = 1'b0;
        fwd      = 1'b0;
        drop_inc = 1'b0;
        case (state_q)
            IDLE: begin
                target = head_dest;
                // oen is only consulted here, so mid-packet changes cannot reroute.
                if (oen[head_dest]) begin
                    fwd   = 1'b1;
                    ready = free[head_dest];
                    if (accept) begin
                        dest_d = head_dest;
                        if (!s_axis_tlast) state_d = FWD;
                    end
                end else begin
                    ready = 1'b1;
                    if (accept) begin
                        if (s_axis_tlast) drop_inc = 1'b1;
                        else              state_d  = DROP;
                    end
                end
            end
            FWD: begin
                fwd   = 1'b1;
                ready = free[dest_q];
                if (accept && s_axis_tlast) state_d = IDLE;
            end
            DROP: begin
                ready = 1'b1;
                if (accept && s_axis_tlast) begin
                    state_d  = IDLE;
                    drop_inc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_ready = {m03_axis_tready, m02_axis_tready, m01_axis_tready, m00_axis_tready};

    for (genvar i = 0; i < N_OUT; i++) begin : g_out
        assign load[i] = accept && fwd && (target == DEST_W'(i));
        axis_dispatch_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out_reg (
            .clk           (clk),
            .rst_n         (rst_n),
            .load          (load[i]),
            .load_data     (s_axis_tdata),
            .load_last     (s_axis_tlast),
            .free          (free[i]),
            .m_axis_tvalid (o_valid[i]),
            .m_axis_tdata  (o_data[i]),
            .m_axis_tlast  (o_last[i]),
            .m_axis_tready (o_ready[i])
        );
    end

    assign m00_axis_tvalid = o_valid[0];
    assign m00_axis_tdata  = o_data[0];
    assign m00_axis_tlast  = o_last[0];
    assign m01_axis_tvalid = o_valid[1];
    assign m01_axis_tdata  = o_data[1];
    assign m01_axis_tlast  = o_last[1];
    assign m02_axis_tvalid = o_valid[2];
    assign m02_axis_tdata  = o_data[2];
    assign m02_axis_tlast  = o_last[2];
    assign m03_axis_tvalid = o_valid[3];
    assign m03_axis_tdata  = o_data[3];
    assign m03_axis_tlast  = o_last[3];

`ifdef AXIS_DISPATCH_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt <= 16'h0000;
        else if (drop_inc && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'h0001;
    end
`else
    logic unused_drop_inc;
    assign unused_drop_inc = drop_inc;
    assign drop_cnt        = 16'h0000;
`endif
endmodule
